// File: rtl/alt_vipvfr131_common_mode_encoder.sv
// Registered one-hot to 1-based binary mode encoder with valid/ready flow control and malformed-vector flags.
// Optional change counter: define ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN to add the change_count port.
module alt_vipvfr131_common_mode_encoder #(
    parameter int NO_OF_MODES      = 3,
    parameter int LOG2_NO_OF_MODES = 2,
    parameter int PRIORITY_HIGH    = 0,
    parameter int HOLD_ON_NONE     = 0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NO_OF_MODES-1:0]      one_hot,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LOG2_NO_OF_MODES-1:0] binary,
    output logic                        multi_hot,
    output logic                        none_hot,
    output logic                        mode_changed,
    output logic                        error_sticky,
    input  logic                        clear_error
`ifdef ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN
    ,
    output logic [15:0]                 change_count
`endif
);

    localparam int W = LOG2_NO_OF_MODES;

    logic [NO_OF_MODES-1:0] sel;
    logic [W-1:0]           term [NO_OF_MODES];
    logic [W-1:0]           enc_code;
    logic                   multi_c;
    logic                   none_c;
    logic                   accept;
    logic [W-1:0]           new_code;
    logic                   new_changed;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] binary_q, binary_d;
    logic         multi_hot_q, multi_hot_d;
    logic         none_hot_q, none_hot_d;
    logic         mode_changed_q, mode_changed_d;
    logic         error_sticky_q, error_sticky_d;
    logic [W-1:0] last_code_q, last_code_d;

    // A set bit survives the mask only if no higher-priority bit is also set.
    genvar g;
    generate
        for (g = 0; g < NO_OF_MODES; g++) begin : g_mask
            if (PRIORITY_HIGH == 0) begin : g_low
                if (g == 0) begin : g_first
                    assign sel[g] = one_hot[g];
                end else begin : g_rest
                    assign sel[g] = one_hot[g] & ~(|one_hot[g-1:0]);
                end
            end else begin : g_high
                if (g == NO_OF_MODES-1) begin : g_first
                    assign sel[g] = one_hot[g];
                end else begin : g_rest
                    assign sel[g] = one_hot[g] & ~(|one_hot[NO_OF_MODES-1:g+1]);
                end
            end
            assign term[g] = sel[g] ? W'(g + 1) : '0;
        end
    endgenerate

    always_comb begin
        enc_code = '0;
        for (int i = 0; i < NO_OF_MODES; i++) begin
            enc_code = enc_code | term[i];
        end
    end

    assign multi_c = |(one_hot & ~sel);
    assign none_c  = ~(|one_hot);

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        new_code = enc_code;
        if (none_c) begin
            new_code = (HOLD_ON_NONE != 0) ? last_code_q : '0;
        end
        new_changed = (new_code != last_code_q);

        out_valid_d    = out_valid_q;
        binary_d       = binary_q;
        multi_hot_d    = multi_hot_q;
        none_hot_d     = none_hot_q;
        mode_changed_d = mode_changed_q;
        last_code_d    = last_code_q;
        error_sticky_d = error_sticky_q;

        if (accept) begin
            out_valid_d    = 1'b1;
            binary_d       = new_code;
            multi_hot_d    = multi_c;
            none_hot_d     = none_c;
            mode_changed_d = new_changed;
            if (!(none_c && (HOLD_ON_NONE != 0))) begin
                last_code_d = new_code;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear_error) begin
            error_sticky_d = 1'b0;
        end
        if (accept && (multi_c || none_c)) begin
            error_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q    <= 1'b0;
            binary_q       <= '0;
            multi_hot_q    <= 1'b0;
            none_hot_q     <= 1'b0;
            mode_changed_q <= 1'b0;
            error_sticky_q <= 1'b0;
            last_code_q    <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            binary_q       <= binary_d;
            multi_hot_q    <= multi_hot_d;
            none_hot_q     <= none_hot_d;
            mode_changed_q <= mode_changed_d;
            error_sticky_q <= error_sticky_d;
            last_code_q    <= last_code_d;
        end
    end

`ifdef ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN
    logic [15:0] change_count_q, change_count_d;

    // Clear and increment in one cycle leave the count at 1, mirroring set-wins on error_sticky.
    always_comb begin
        change_count_d = change_count_q;
        if (clear_error) begin
            change_count_d = '0;
        end
        if (accept && new_changed && (change_count_d != 16'hFFFF)) begin
            change_count_d = change_count_d + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            change_count_q <= '0;
        end else begin
            change_count_q <= change_count_d;
        end
    end

    assign change_count = change_count_q;
`endif

    assign out_valid    = out_valid_q;
    assign binary       = binary_q;
    assign multi_hot    = multi_hot_q;
    assign none_hot     = none_hot_q;
    assign mode_changed = mode_changed_q;
    assign error_sticky = error_sticky_q;

endmodule

// File: tb/tb_alt_vipvfr131_common_mode_encoder.sv
// Bench for the mode encoder: three parameterisations checked every cycle against a transaction-level model.
module tb_alt_vipvfr131_common_mode_encoder;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic       iv_a = 1'b0, or_a = 1'b1, clr_a = 1'b0;
    logic [2:0] oh_a = '0;
    logic        iv_b = 1'b0, or_b = 1'b1, clr_b = 1'b0;
    logic [39:0] oh_b = '0;

    logic rdy [3];
    logic ov  [3];
    logic mh  [3];
    logic nh  [3];
    logic mc  [3];
    logic es  [3];
    logic [1:0] bin0, bin1;
    logic [5:0] bin2;
`ifdef ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN
    logic [15:0] cc0, cc1, cc2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    alt_vipvfr131_common_mode_encoder #(
        .NO_OF_MODES(3), .LOG2_NO_OF_MODES(2), .PRIORITY_HIGH(0), .HOLD_ON_NONE(0)
    ) d0 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv_a), .in_ready(rdy[0]),
        .one_hot(oh_a), .out_valid(ov[0]), .out_ready(or_a), .binary(bin0),
        .multi_hot(mh[0]), .none_hot(nh[0]), .mode_changed(mc[0]),
        .error_sticky(es[0]), .clear_error(clr_a)
`ifdef ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN
        , .change_count(cc0)
`endif
    );

    alt_vipvfr131_common_mode_encoder #(
        .NO_OF_MODES(3), .LOG2_NO_OF_MODES(2), .PRIORITY_HIGH(1), .HOLD_ON_NONE(1)
    ) d1 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv_a), .in_ready(rdy[1]),
        .one_hot(oh_a), .out_valid(ov[1]), .out_ready(or_a), .binary(bin1),
        .multi_hot(mh[1]), .none_hot(nh[1]), .mode_changed(mc[1]),
        .error_sticky(es[1]), .clear_error(clr_a)
`ifdef ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN
        , .change_count(cc1)
`endif
    );

    alt_vipvfr131_common_mode_encoder #(
        .NO_OF_MODES(40), .LOG2_NO_OF_MODES(6), .PRIORITY_HIGH(0), .HOLD_ON_NONE(0)
    ) d2 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv_b), .in_ready(rdy[2]),
        .one_hot(oh_b), .out_valid(ov[2]), .out_ready(or_b), .binary(bin2),
        .multi_hot(mh[2]), .none_hot(nh[2]), .mode_changed(mc[2]),
        .error_sticky(es[2]), .clear_error(clr_b)
`ifdef ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN
        , .change_count(cc2)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic [6:0]  bin;
        logic        multi;
        logic        none;
        logic        chg;
        logic        err;
        logic [6:0]  last;
        logic [15:0] cnt;
    } mdl_t;

    mdl_t m0, m1, m2;

    // One transaction step of the encoder, written from the rules: count set bits, pick winner, register.
    function automatic mdl_t step(mdl_t s, logic iv, logic [63:0] oh, logic ordy, logic clr,
                                  int n, int ph, int hold);
        mdl_t t = s;
        int nset = 0;
        int lo = -1;
        int hi = -1;
        int code;
        if (clr) begin
            t.err = 1'b0;
            t.cnt = '0;
        end
        if (iv && (!s.valid || ordy)) begin
            for (int i = 0; i < n; i++) begin
                if (oh[i]) begin
                    nset++;
                    if (lo < 0) lo = i;
                    hi = i;
                end
            end
            if (nset == 0) code = (hold != 0) ? int'(s.last) : 0;
            else           code = ((ph != 0) ? hi : lo) + 1;
            t.valid = 1'b1;
            t.bin   = 7'(code);
            t.multi = (nset > 1);
            t.none  = (nset == 0);
            t.chg   = (7'(code) != s.last);
            if (!(nset == 0 && hold != 0)) t.last = 7'(code);
            if (t.multi || t.none) t.err = 1'b1;
            if (t.chg && t.cnt != 16'hFFFF) t.cnt = t.cnt + 16'd1;
        end else if (ordy) begin
            t.valid = 1'b0;
        end
        return t;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m0 <= '0;
            m1 <= '0;
            m2 <= '0;
        end else begin
            m0 <= step(m0, iv_a, 64'(oh_a), or_a, clr_a, 3, 0, 0);
            m1 <= step(m1, iv_a, 64'(oh_a), or_a, clr_a, 3, 1, 1);
            m2 <= step(m2, iv_b, 64'(oh_b), or_b, clr_b, 40, 0, 0);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string nm, input mdl_t e, input logic ordy, input logic r,
                       input logic v, input logic [6:0] b, input logic mhv, input logic nhv,
                       input logic mcv, input logic esv);
        chk({nm, ".in_ready"}, 64'(r), 64'(!e.valid || ordy));
        chk({nm, ".out_valid"}, 64'(v), 64'(e.valid));
        chk({nm, ".error_sticky"}, 64'(esv), 64'(e.err));
        if (e.valid) begin
            chk({nm, ".binary"}, 64'(b), 64'(e.bin));
            chk({nm, ".multi_hot"}, 64'(mhv), 64'(e.multi));
            chk({nm, ".none_hot"}, 64'(nhv), 64'(e.none));
            chk({nm, ".mode_changed"}, 64'(mcv), 64'(e.chg));
        end
    endtask

    always @(negedge clock) begin
        cmp("d0", m0, or_a, rdy[0], ov[0], 7'(bin0), mh[0], nh[0], mc[0], es[0]);
        cmp("d1", m1, or_a, rdy[1], ov[1], 7'(bin1), mh[1], nh[1], mc[1], es[1]);
        cmp("d2", m2, or_b, rdy[2], ov[2], 7'(bin2), mh[2], nh[2], mc[2], es[2]);
`ifdef ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN
        chk("d0.change_count", 64'(cc0), 64'(m0.cnt));
        chk("d1.change_count", 64'(cc1), 64'(m1.cnt));
        chk("d2.change_count", 64'(cc2), 64'(m2.cnt));
`endif
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("lit_rst_valid", 64'(ov[0]), 64'd0);
        chk("lit_rst_binary", 64'(bin0), 64'd0);
        chk("lit_rst_err", 64'(es[0]), 64'd0);
        chk("lit_rst_ready", 64'(rdy[0]), 64'd1);
        reset_n = 1'b1;

        iv_a = 1'b1; oh_a = 3'b001; tick();
        chk("lit_enc_001", 64'(bin0), 64'd1);
        chk("lit_chg_001", 64'(mc[0]), 64'd1);
        oh_a = 3'b010; tick();
        chk("lit_enc_010", 64'(bin0), 64'd2);
        oh_a = 3'b100; tick();
        chk("lit_enc_100", 64'(bin0), 64'd3);
        chk("lit_flag_100", 64'({mh[0], nh[0]}), 64'd0);
        oh_a = 3'b110; tick();
        chk("lit_multi_lo_bin", 64'(bin0), 64'd2);
        chk("lit_multi_lo_flag", 64'(mh[0]), 64'd1);
        chk("lit_multi_err", 64'(es[0]), 64'd1);
        chk("lit_multi_hi_bin", 64'(bin1), 64'd3);
        oh_a = 3'b010; tick();
        chk("lit_mode2", 64'(bin1), 64'd2);
        oh_a = 3'b000; tick();
        chk("lit_none_bin", 64'(bin0), 64'd0);
        chk("lit_none_flag", 64'(nh[0]), 64'd1);
        chk("lit_none_chg", 64'(mc[0]), 64'd1);
        chk("lit_hold_bin", 64'(bin1), 64'd2);
        chk("lit_hold_chg", 64'(mc[1]), 64'd0);

        oh_a = 3'b001; or_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lit_bp_ready", 64'(rdy[0]), 64'd0);
            chk("lit_bp_hold", 64'(bin0), 64'd0);
        end
        or_a = 1'b1; tick();
        chk("lit_b2b_1", 64'(bin0), 64'd1);
        oh_a = 3'b010; tick();
        chk("lit_b2b_2", 64'(bin0), 64'd2);
        chk("lit_b2b_valid", 64'(ov[0]), 64'd1);
        oh_a = 3'b100; tick();
        chk("lit_b2b_3", 64'(bin0), 64'd3);
        iv_a = 1'b0; tick();
        chk("lit_drain", 64'(ov[0]), 64'd0);

        clr_a = 1'b1; iv_a = 1'b1; oh_a = 3'b011; tick();
        chk("lit_clr_setwins", 64'(es[0]), 64'd1);
        iv_a = 1'b0; tick();
        chk("lit_clr_alone", 64'(es[0]), 64'd0);
        clr_a = 1'b0; tick();

        iv_b = 1'b1;
        for (int i = 0; i < 40; i++) begin
            oh_b = 40'd1 << i;
            tick();
            chk("lit_walk", 64'(bin2), 64'(i + 1));
        end
`ifdef ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN
        chk("lit_walk_count", 64'(cc2), 64'd40);
`endif
        oh_b = (40'd1 << 3) | (40'd1 << 39); tick();
        chk("lit_wide_multi", 64'(bin2), 64'd4);
        oh_b = 40'd1 << 5; tick();
        #2 reset_n = 1'b0;
        #1;
        chk("lit_midrst_valid", 64'(ov[2]), 64'd0);
        chk("lit_midrst_bin", 64'(bin2), 64'd0);
        chk("lit_midrst_flags", 64'({mh[2], nh[2], mc[2], es[2]}), 64'd0);
`ifdef ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN
        chk("lit_midrst_count", 64'(cc2), 64'd0);
`endif
        @(posedge clock); #1;
        iv_b = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("lit_post_rst_ready", 64'(rdy[2]), 64'd1);
        iv_b = 1'b1; oh_b = 40'd1; tick();
        chk("lit_post_rst_bin", 64'(bin2), 64'd1);
        chk("lit_post_rst_chg", 64'(mc[2]), 64'd1);
        iv_b = 1'b0; tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alt_vipvfr131_common_mode_encoder.md
Name: alt_vipvfr131_common_mode_encoder

Overview:
- Registered, flow-controlled successor to the team's combinational one-hot-to-binary mode encoder.
- Takes a one-hot mode vector over a valid/ready handshake and emits a 1-based binary mode code (0 = no mode).
- Also flags malformed vectors (multi-hot, none-hot), resolves multi-hot by a configurable priority, and tracks mode changes.
- Sits between VIP control-register decode and the frame-reader mode muxes.

Parameters:
- NO_OF_MODES, 3, width of the one-hot input; legal range 2..64.
- LOG2_NO_OF_MODES, 2, output code width; must satisfy 2^LOG2_NO_OF_MODES > NO_OF_MODES.
- PRIORITY_HIGH, 0, multi-hot resolution: 0 = lowest set index wins; 1 = highest set index wins.
- HOLD_ON_NONE, 0, none-hot handling: 0 = output code 0; 1 = output repeats last accepted non-zero code (0 if none since reset).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  one_hot is valid.
- in_ready  out  1  block can accept; in_ready = !out_valid || out_ready (combinational).
- one_hot  in  NO_OF_MODES  mode vector.
- out_valid  out  1  binary and flags are valid.
- out_ready  in  1  downstream accepts.
- binary  out  LOG2_NO_OF_MODES  encoded mode, index+1; 0 = none.
- multi_hot  out  1  accepted vector had >1 bit set; qualified by out_valid.
- none_hot  out  1  accepted vector had 0 bits set; qualified by out_valid.
- mode_changed  out  1  binary differs from the previous emitted binary; qualified by out_valid.
- error_sticky  out  1  set on any accepted multi_hot or none_hot; held until clear_error.
- clear_error  in  1  synchronous clear of error_sticky.

Behaviour:
- Reset values, asynchronous on reset_n low:
  - out_valid, binary, multi_hot, none_hot, mode_changed, error_sticky = 0.
  - Internal last_code = 0.
- Accept occurs when in_valid && in_ready.
  - Outputs register on the next rising edge; latency is 1 cycle.
  - Throughput is 1 per cycle while out_ready is high.
- Output register:
  - On accept: load out_valid = 1 plus the new code and flags.
  - Else if out_ready: out_valid = 0.
  - Else: hold all output fields stable. Fields must not change while out_valid && !out_ready.
- Encoding:
  - Exactly one bit i set: binary = i+1.
  - Multi-hot: binary = (priority index)+1 and multi_hot = 1.
  - None-hot: none_hot = 1; binary = 0, or last_code when HOLD_ON_NONE = 1.
  - Arithmetic is unsigned and truncated to LOG2_NO_OF_MODES bits. The parameter rule guarantees no truncation.
- last_code updates on each accept to the emitted binary, except when none-hot and HOLD_ON_NONE = 1 (it is unchanged then).
- mode_changed = (new binary != last_code before the update). The first accept after reset compares against 0.
- error_sticky:
  - Sets on an accept with multi_hot or none_hot.
  - clear_error clears it.
  - If both occur in the same cycle, set wins.
- Simultaneous accept and drain (out_valid && out_ready && in_valid): the new item loads, out_valid stays 1, and there is no bubble.
- reset_n asserted mid-transfer: the in-flight item is discarded. in_ready is 1 one cycle after release.
- Sequential state is limited to the output register, last_code, error_sticky, and the optional counter. Encoding is a generate-loop OR-reduction tree with priority masking, with no latches.

Optional Feature:
- Macro: ALT_VIPVFR131_MODE_ENCODER_CHANGE_COUNT_EN.
- When defined:
  - Adds output port change_count (16 bits).
  - Increments on every accept with mode_changed = 1 and saturates at 16'hFFFF.
  - Reset value is 0. clear_error also zeroes it.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset then single accepts, defaults: one_hot = 3'b001, 3'b010, 3'b100 -> binary 1, 2, 3 one cycle later; mode_changed = 1 on each; flags 0.
- Multi-hot 3'b110 with PRIORITY_HIGH = 0 -> binary = 2, multi_hot = 1, error_sticky = 1. With PRIORITY_HIGH = 1 -> binary = 3.
- None-hot 3'b000 after mode 2:
  - HOLD_ON_NONE = 0 -> binary 0, none_hot = 1, mode_changed = 1.
  - HOLD_ON_NONE = 1 -> binary 2, mode_changed = 0.
- Backpressure: out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0; outputs stable. Then out_ready = 1 with back-to-back inputs -> one result per cycle with no bubble.
- clear_error and a new error in the same cycle -> error_sticky stays 1. clear_error alone -> error_sticky 0 next cycle.
- NO_OF_MODES = 40, LOG2_NO_OF_MODES = 6, macro defined:
  - Walk bits 0..39 -> binary 1..40; change_count = 40.
  - Assert reset_n low mid-stream -> all outputs 0 immediately.
